// File: rtl/cnn_window_scheduler.sv
// Window sequencer: sweeps a SIZE x SIZE stride-1 window over a feature map in single-port SRAM,
// packs each window's pixels and presents them with a latched kernel over valid/ready.
module cnn_window_scheduler #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] kernel_in,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] win_data,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] win_kernel,
    output logic [7:0]                      win_row,
    output logic [7:0]                      win_col,
    output logic                            win_last
);

    localparam int NPIX = SIZE * SIZE;
    localparam int KW   = $clog2(NPIX + 1);
    localparam int IW   = $clog2(SIZE + 1);
    localparam logic [7:0]    LAST_ROW  = 8'(IMG_H - SIZE);
    localparam logic [7:0]    LAST_COL  = 8'(IMG_W - SIZE);
    localparam logic [IW-1:0] EDGE_LAST = IW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] fetch_i;
    logic [IW-1:0] fetch_j;
    logic [KW-1:0] rd_idx;
    logic          rd_pending;
    logic          fetch_last;
    logic          at_last;

    assign fetch_last = (fetch_i == EDGE_LAST) && (fetch_j == EDGE_LAST);
    assign at_last    = (win_row == LAST_ROW) && (win_col == LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: if (fetch_last) state_next = S_DRAIN;
            S_DRAIN: state_next = S_ISSUE;
            S_ISSUE: if (win_ready) state_next = at_last ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        win_valid = 1'b0;
        win_last  = 1'b0;
        case (state)
            S_FETCH: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_WIDTH'((32'(win_row) + 32'(fetch_i)) * 32'(IMG_W)
                                        + 32'(win_col) + 32'(fetch_j));
            end
            S_DRAIN: busy = 1'b1;
            S_ISSUE: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                win_last  = at_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Read data lands one cycle after its strobe, so the slot index is pipelined alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_i    <= '0;
            fetch_j    <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            win_data   <= '0;
            win_kernel <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            rd_pending <= (state == S_FETCH);
            rd_idx     <= KW'(32'(fetch_i) * 32'(SIZE) + 32'(fetch_j));
            for (int s = 0; s < NPIX; s++) begin
                if (rd_pending && (rd_idx == KW'(s))) begin
                    win_data[s*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        win_kernel <= kernel_in;
                        win_row    <= '0;
                        win_col    <= '0;
                        fetch_i    <= '0;
                        fetch_j    <= '0;
                    end
                end
                S_FETCH: begin
                    if (fetch_j == EDGE_LAST) begin
                        fetch_j <= '0;
                        fetch_i <= fetch_last ? '0 : fetch_i + IW'(1);
                    end else begin
                        fetch_j <= fetch_j + IW'(1);
                    end
                end
                S_ISSUE: begin
                    if (win_ready && !at_last) begin
                        if (win_col == LAST_COL) begin
                            win_col <= '0;
                            win_row <= win_row + 8'd1;
                        end else begin
                            win_col <= win_col + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
